counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
Programmable controller that sequences a WIDTH-bit synchronous up-counter datapath. Features:
- start/pause/resume/clear control
- programmable terminal value (Limit)
- clock prescaler
- one-shot or periodic mode
- one-cycle Done pulse and a Busy flag

It sits between control logic and the counter datapath, so that no JK-level counter is driven directly.

Parameters:
WIDTH, 4, counter width in bits (Q and Limit).
PRE_W, 4, prescaler width in bits; a step occurs every Prescale+1 clocks.

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
Rst_n  input  1  asynchronous active-low reset.
Start  input  1  IDLE: latch configuration and begin. PAUSE: resume. RUN: ignored.
Stop  input  1  RUN: pause. Other states: ignored.
Clear  input  1  synchronous abort to IDLE from any state.
Mode  input  1  0 = one-shot, 1 = periodic. Sampled only on Start in IDLE.
Limit  input  WIDTH  terminal count value. Sampled only on Start in IDLE.
Prescale  input  PRE_W  step divider value P. Sampled only on Start in IDLE.
Q  output  WIDTH  current count.
Busy  output  1  high in RUN or PAUSE.
Paused  output  1  high in PAUSE.
Done  output  1  one-cycle pulse at terminal count.

Behaviour:
- Reset (Rst_n low, asynchronous): state=IDLE, Q=0, prescaler=0, latched Limit/Mode/Prescale=0, Done=0, Busy=0, Paused=0.
- States are IDLE, RUN and PAUSE. All outputs are registered.
- Input priority within a cycle: Clear > Stop > Start.
- IDLE:
  - Start=1: latch Limit, Mode and Prescale; Q<=0; prescaler<=0; go to RUN.
  - Otherwise Q holds its value (after one-shot completion it holds Limit).
- RUN:
  - Prescaler increments each clock while pre != P.
  - When pre == P, a step occurs: pre<=0.
    - If Q != Limit_lat: Q<=Q+1.
    - If Q == Limit_lat, one-shot: Done=1 next cycle, go to IDLE, Q holds Limit_lat.
    - If Q == Limit_lat, periodic: Done=1 next cycle, Q<=0, stay in RUN.
  - Stop=1: go to PAUSE. No step occurs on that edge; Q and pre freeze.
  - Start is ignored. Changes to Limit/Mode/Prescale are ignored.
- PAUSE:
  - Q and pre are frozen.
  - Start=1: return to RUN and continue from the frozen values, with no reload.
  - Stop is ignored.
- Clear=1 in any state: state=IDLE, Q=0, pre=0, Done=0 on the next edge. A terminal step coinciding with Clear is discarded, so no Done is produced.
- Timing: Start sampled at edge k gives RUN after edge k. The first step is at edge k+1+P, so Q=1 after that edge. With P=0, Q advances every clock.
- Done period:
  - Periodic: (Limit+1)*(P+1) clocks.
  - One-shot: Done appears after edge k+(Limit+1)*(P+1).
- Limit=0: each step is terminal. One-shot gives Done after edge k+1+P with Q=0. Periodic gives Done every P+1 clocks with Q staying at 0.
- No arithmetic overflow: Q never exceeds Limit_lat ≤ 2^WIDTH-1, and wrap is explicit. Limit=2^WIDTH-1 is legal.
- Done is never high for two consecutive cycles unless periodic with Limit=0 and P=0. In that case Done stays high continuously while RUN is held.
- Asynchronous reset mid-operation returns immediately to the reset values, independent of Clk.

Decomposition:
- Shared package/include counter_sequencer_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2
  - MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1
- One sub-module: count_core (Clk, Rst_n, En, Clr, Q). It is a WIDTH-bit synchronous up-counter:
  - Clr has priority over En.
  - It is driven by the sequencer FSM plus the prescaler.
  - The terminal compare and Done logic live in counter_sequencer.

Test Plan:
- One-shot, Limit=3, P=0, Start at edge 0 -> Q=1,2,3 after edges 1,2,3. Edge 4: Done=1 for one cycle, Busy=0, Q holds 3.
- Periodic, Limit=2, P=1 -> Q steps every 2 clocks: 0,1,2,0,1,2. Done pulses every 6 clocks. Busy stays 1.
- Pause/resume: periodic, Limit=5, P=0. Stop when Q=2 -> Paused=1 and Q stays 2 for 4 cycles. Start -> Q=3 after the next edge. Done timing shifts by exactly the paused cycles.
- Clear/priority: Clear+Stop+Start in the same cycle during RUN -> IDLE, Q=0, no Done. Clear on the terminal-step cycle -> Done stays 0.
- Config isolation and Limit=0: changing Limit/Prescale/Mode during RUN has no effect. One-shot Limit=0, P=2 -> Done after edge 3, Q=0.
- Async reset: drop Rst_n mid-RUN between clock edges -> Q=0, Busy=0, Done=0 immediately. After release, Start restarts cleanly.

Source files
------------

// File: rtl/counter_sequencer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | counter_sequencer_pkg: shared state and mode encodings          |
// | Rev 1.0 - initial release                                       |
// +-----------------------------------------------------------------+
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/counter_sequencer_count_core.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | count_core: WIDTH-bit synchronous up-counter, clear beats enable |
// | Rev 1.0 - initial release                                       |
// +-----------------------------------------------------------------+
module count_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | counter_sequencer: start/pause/clear FSM with prescaler driving |
// | a count_core datapath. Rev 1.0 - initial release                |
// +-----------------------------------------------------------------+
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  state_t           r_state, w_state_nxt;
  logic [PRE_W-1:0] r_pre, w_pre_nxt;
  logic [WIDTH-1:0] r_limit;
  logic [PRE_W-1:0] r_prescale;
  logic             r_mode;
  logic             r_done, w_done_nxt;
  logic             r_busy, r_paused;
  logic             w_latch, w_cnt_en, w_cnt_clr;
  logic [WIDTH-1:0] w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pre      <= '0;
      r_limit    <= '0;
      r_prescale <= '0;
      r_mode     <= MODE_ONESHOT;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_paused   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pre    <= w_pre_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_paused <= (w_state_nxt == ST_PAUSE);
      if (w_latch) begin
        r_limit    <= limit;
        r_prescale <= prescale;
        r_mode     <= mode;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_done_nxt  = 1'b0;
    w_latch     = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_clr   = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_pre_nxt   = '0;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_latch     = 1'b1;
            w_cnt_clr   = 1'b1;
            w_pre_nxt   = '0;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            w_state_nxt = ST_PAUSE;
          end else if (r_pre == r_prescale) begin
            // step edge: either advance or hit the terminal count
            w_pre_nxt = '0;
            if (w_q != r_limit) begin
              w_cnt_en = 1'b1;
            end else begin
              w_done_nxt = 1'b1;
              if (r_mode == MODE_PERIODIC) begin
                w_cnt_clr = 1'b1;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end
          end else begin
            w_pre_nxt = r_pre + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_pre_nxt   = '0;
          w_cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  count_core #(
    .WIDTH (WIDTH)
  ) u_count_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_cnt_en),
    .clr   (w_cnt_clr),
    .q     (w_q)
  );

  assign q      = w_q;
  assign busy   = r_busy;
  assign paused = r_paused;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_counter_sequencer: directed and random stimulus vs. a model  |
// | Rev 1.0 - initial release                                       |
// +-----------------------------------------------------------------+
module tb_counter_sequencer;

  localparam int WIDTH = 4;
  localparam int PRE_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, stop = 1'b0, clear = 1'b0, mode = 1'b0;
  logic [WIDTH-1:0] limit = '0;
  logic [PRE_W-1:0] prescale = '0;
  logic [WIDTH-1:0] q;
  logic             busy, paused, done;

  int n_tests = 0;
  int n_fail  = 0;

  // model: the count is derived from the number of un-paused RUN clocks
  int m_busy, m_paused, m_done, m_q, m_n, m_lim, m_p, m_per;

  counter_sequencer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .mode(mode), .limit(limit), .prescale(prescale),
    .q(q), .busy(busy), .paused(paused), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_paused = 0; m_done = 0; m_q = 0; m_n = 0;
    m_lim = 0; m_p = 0; m_per = 0;
  endtask

  task automatic model_step();
    int s;
    m_done = 0;
    if (clear) begin
      m_busy = 0; m_paused = 0; m_q = 0; m_n = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_paused = 0; m_q = 0; m_n = 0;
        m_lim = int'(limit); m_p = int'(prescale); m_per = int'(mode);
      end
    end else if (m_paused) begin
      if (start) m_paused = 0;
    end else if (stop) begin
      m_paused = 1;
    end else begin
      m_n++;
      if (m_n % (m_p + 1) == 0) begin
        s = m_n / (m_p + 1);
        if (s % (m_lim + 1) == 0) begin
          m_done = 1;
          if (m_per != 0) m_q = 0;
          else begin m_busy = 0; m_q = m_lim; end
        end else begin
          m_q = s % (m_lim + 1);
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("q", 32'(q), 32'(m_q));
    check("busy", 32'(busy), 32'(m_busy));
    check("paused", 32'(paused), 32'(m_paused));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic go(input logic md, input int lim, input int p);
    mode = md; limit = WIDTH'(lim); prescale = PRE_W'(p);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_q", 32'(q), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_paused", 32'(paused), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int dones;
    model_reset();
    #12;
    check("rst_q", 32'(q), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // one-shot, Limit=3, P=0
    go(1'b0, 3, 0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check("os_q", 32'(q), 32'(i));
    end
    cycle();
    check("os_done", 32'(done), 32'd1);
    check("os_busy", 32'(busy), 32'd0);
    check("os_hold", 32'(q), 32'd3);
    cycle();
    check("os_done_pulse", 32'(done), 32'd0);

    // periodic, Limit=2, P=1: two Done pulses in 12 clocks
    go(1'b1, 2, 1);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      limit = WIDTH'($urandom);
      prescale = PRE_W'($urandom);
      mode = 1'($urandom);
      cycle();
      dones += int'(done);
    end
    check("per_dones", 32'(dones), 32'd2);
    check("per_busy", 32'(busy), 32'd1);
    clear = 1'b1; cycle(); clear = 1'b0;

    // pause/resume, periodic Limit=5, P=0
    go(1'b1, 5, 0);
    cycle(); cycle();
    stop = 1'b1; cycle(); stop = 1'b0;
    check("pz_paused", 32'(paused), 32'd1);
    for (int i = 0; i < 3; i++) cycle();
    check("pz_hold", 32'(q), 32'd2);
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    check("pz_resume", 32'(q), 32'd3);

    // clear+stop+start together during RUN
    clear = 1'b1; stop = 1'b1; start = 1'b1; cycle();
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_q", 32'(q), 32'd0);

    // clear on the terminal step discards Done
    go(1'b0, 1, 0);
    cycle();
    clear = 1'b1; cycle(); clear = 1'b0;
    check("clr_term_done", 32'(done), 32'd0);

    // one-shot Limit=0, P=2
    go(1'b0, 0, 2);
    cycle(); cycle();
    check("l0_early", 32'(done), 32'd0);
    cycle();
    check("l0_done", 32'(done), 32'd1);
    check("l0_q", 32'(q), 32'd0);

    // periodic Limit=0, P=0: Done held high
    go(1'b1, 0, 0);
    cycle(); cycle();
    check("l0p0_done", 32'(done), 32'd1);

    // async reset mid-RUN, then clean restart
    go(1'b1, 7, 1);
    for (int i = 0; i < 5; i++) cycle();
    async_reset();
    go(1'b0, 2, 0);
    for (int i = 0; i < 4; i++) cycle();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 9) == 0);
      stop = ($urandom_range(0, 19) == 0);
      clear = ($urandom_range(0, 59) == 0);
      mode = 1'($urandom);
      limit = WIDTH'($urandom);
      prescale = ($urandom_range(0, 7) == 0) ? PRE_W'($urandom) : PRE_W'($urandom_range(0, 2));
      cycle();
      if ($urandom_range(0, 999) == 0) async_reset();
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
